// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding the RV32 decoder.
//   Holds the PC and issues one word read at a time on a valid/ready
//   request channel. The response channel is valid-only. The fetched word
//   is presented to decode, together with its PC, on a valid/ready handshake.
//   Execute can redirect fetch at any time; a fetch that is still in flight
//   at that point is drained and its data is dropped.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   imem_req_valid/ready/addr        fetch request channel (addr = pc)
//   imem_rsp_valid/data              read response, one per accepted request
//   inst_valid/ready, inst, inst_pc  registered instruction to decoder
//   redirect_valid/pc                single-cycle control-flow change
//   fetch_err                        sticky misaligned-redirect flag
module ifu_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_err
);

  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_ERR} state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] pc, pc_nx;
  logic            err_nx;
  logic            misal;
  logic            outstanding;

  assign misal          = (redirect_pc[1:0] != 2'b00);
  assign imem_req_valid = (state == S_REQ) && rst_n;
  assign imem_req_addr  = pc;

  // A request is still owed a response after this cycle: either it is being
  // accepted right now, or we are already waiting and nothing arrived.
  assign outstanding = ((state == S_REQ)   &&  imem_req_ready) ||
                       ((state == S_WAIT)  && !imem_rsp_valid) ||
                       ((state == S_DRAIN) && !imem_rsp_valid);

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    err_nx   = fetch_err;
    case (state)
      S_REQ:   if (imem_req_ready) state_nx = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_nx = S_HOLD;
      S_HOLD:  if (inst_ready) begin
                 state_nx = S_REQ;
                 pc_nx    = pc + 32'd4;
               end
      // fetch_err set while draining means the pending target was
      // misaligned, so the drain ends in ERR rather than a new fetch.
      S_DRAIN: if (imem_rsp_valid) state_nx = fetch_err ? S_ERR : S_REQ;
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_REQ;
    endcase
    // Redirect overrides everything, including a same-cycle decode handshake.
    if (redirect_valid) begin
      pc_nx    = redirect_pc;
      err_nx   = misal;
      state_nx = outstanding ? S_DRAIN : (misal ? S_ERR : S_REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      fetch_err  <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      fetch_err  <= err_nx;
      inst_valid <= (state_nx == S_HOLD);
      if ((state == S_WAIT) && (state_nx == S_HOLD)) begin
        inst    <= imem_rsp_data;
        inst_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: memory and decoder are driven by hand,
// one step per clock, with expected values written out in each step.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  int n_vec = 0;
  int n_bad = 0;

  ifu_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered in REQ; leaves the DUT in HOLD presenting data.
  task automatic to_hold(input logic [31:0] addr, input logic [31:0] data);
    check("req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("req_addr", imem_req_addr, addr);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    check("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    cyc();
    imem_rsp_valid = 1'b0;
    check("hold_valid", {31'd0, inst_valid}, 32'd1);
    check("hold_inst", inst, data);
    check("hold_pc", inst_pc, addr);
  endtask

  task automatic consume();
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    check("consumed_valid", {31'd0, inst_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    cyc(); cyc();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    rst_n = 1'b1;
    #1;

    // Sequential fetch, zero-wait memory.
    to_hold(32'h8000_0000, 32'h0000_0013); consume();
    to_hold(32'h8000_0004, 32'h0010_0093); consume();
    to_hold(32'h8000_0008, 32'h0020_0113); consume();

    // Decoder stalls 5 cycles in HOLD.
    to_hold(32'h8000_000C, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_valid", {31'd0, inst_valid}, 32'd1);
      check("stall_inst", inst, 32'h1234_5678);
      check("stall_pc", inst_pc, 32'h8000_000C);
      check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    consume();
    check("after_stall_addr", imem_req_addr, 32'h8000_0010);

    // Redirect in WAIT; stale response arrives two cycles later.
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    cyc();
    redirect_valid = 1'b0;
    check("drain_no_req", {31'd0, imem_req_valid}, 32'd0);
    check("drain_no_inst", {31'd0, inst_valid}, 32'd0);
    cyc();
    check("drain2_no_req", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    cyc();
    imem_rsp_valid = 1'b0;
    check("stale_dropped", {31'd0, inst_valid}, 32'd0);
    cyc();
    check("stale_dropped2", {31'd0, inst_valid}, 32'd0);
    to_hold(32'h8000_0100, 32'hAAAA_0001); consume();

    // Redirect in HOLD same cycle as inst_ready: target wins over pc+4.
    to_hold(32'h8000_0104, 32'hAAAA_0002);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0040;
    cyc();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    check("redir_hold_valid", {31'd0, inst_valid}, 32'd0);
    check("redir_hold_req", {31'd0, imem_req_valid}, 32'd1);
    check("redir_hold_addr", imem_req_addr, 32'h8000_0040);

    // Misaligned redirect from REQ (not accepted) -> ERR.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    cyc();
    redirect_valid = 1'b0;
    check("err_flag", {31'd0, fetch_err}, 32'd1);
    check("err_no_req", {31'd0, imem_req_valid}, 32'd0);
    check("err_no_inst", {31'd0, inst_valid}, 32'd0);
    cyc(); cyc();
    check("err_sticky", {31'd0, fetch_err}, 32'd1);
    check("err_still_no_req", {31'd0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    cyc();
    redirect_valid = 1'b0;
    check("err_clear", {31'd0, fetch_err}, 32'd0);
    to_hold(32'h8000_0200, 32'hAAAA_0003); consume();

    // Misaligned redirect while WAIT: drain first, then ERR.
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0006;
    cyc();
    redirect_valid = 1'b0;
    check("mdrain_err", {31'd0, fetch_err}, 32'd1);
    check("mdrain_no_req", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    cyc();
    imem_rsp_valid = 1'b0;
    check("mdrain_to_err_req", {31'd0, imem_req_valid}, 32'd0);
    check("mdrain_to_err_inst", {31'd0, inst_valid}, 32'd0);
    cyc();
    check("mdrain_err_no_req", {31'd0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    check("top_err_clear", {31'd0, fetch_err}, 32'd0);

    // PC wrap at top of address space.
    to_hold(32'hFFFF_FFFC, 32'hAAAA_0004); consume();
    check("wrap_addr", imem_req_addr, 32'h0000_0000);

    // Reset while in WAIT.
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    cyc();
    check("mrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("mrst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("mrst_inst", inst, 32'd0);
    check("mrst_inst_pc", inst_pc, 32'd0);
    check("mrst_err", {31'd0, fetch_err}, 32'd0);
    rst_n = 1'b1;
    #1;
    to_hold(32'h8000_0000, 32'hAAAA_0005); consume();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit; the producer end of the instruction interface that feeds the RV32 decoder.
- Holds the PC, issues word reads to instruction memory over a valid/ready request channel, and receives a valid-only response.
- Presents each fetched instruction with its PC to decode over a valid/ready handshake.
- Accepts control-flow redirects from execute, discarding any in-flight stale fetch.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset; must be 4-byte aligned.
- XLEN, 32, address/instruction width; only 32 supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  fetch address (= pc).
- imem_rsp_valid  input  1  read data valid, one per accepted request, in order.
- imem_rsp_data  input  XLEN  instruction word.
- inst_valid  output  1  instruction available to decoder.
- inst_ready  input  1  decoder consumes instruction.
- inst  output  XLEN  instruction word (registered).
- inst_pc  output  XLEN  PC of inst.
- redirect_valid  input  1  control-flow change, single-cycle pulse.
- redirect_pc  input  XLEN  new fetch target.
- fetch_err  output  1  misaligned redirect target, sticky.

Behaviour:
- Reset (rst_n=0 at posedge): pc=RESET_PC, state=REQ, inst_valid=0, inst=0, inst_pc=0, fetch_err=0. imem_req_valid is 0 while rst_n=0.
- At most one outstanding memory request. Responses arrive at least one cycle after acceptance. No response can arrive without an accepted request.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc; both held stable until accepted.
  - req_ready=1 -> WAIT.
- WAIT:
  - On rsp_valid: inst<=rsp_data, inst_pc<=pc, inst_valid<=1 next cycle -> HOLD.
- HOLD:
  - inst_valid=1; inst and inst_pc held stable until inst_ready.
  - On inst_ready: inst_valid<=0, pc<=pc+4 (mod 2^32, wraps to 0) -> REQ.
- DRAIN:
  - A request is outstanding whose data is stale.
  - On rsp_valid: data dropped, inst_valid stays 0 -> REQ.
- ERR:
  - imem_req_valid=0, inst_valid=0.
  - Left only by an aligned redirect or by reset.
- Redirect (highest priority, any state):
  - Aligned target (redirect_pc[1:0]==0): pc<=redirect_pc and fetch_err<=0.
    - REQ with req_ready=0 -> REQ; the address changes next cycle, which is legal because the handshake was not accepted.
    - REQ with req_ready=1 same cycle -> DRAIN; the old address was accepted.
    - WAIT with rsp_valid=0 -> DRAIN.
    - WAIT with rsp_valid=1 same cycle -> REQ; the response is dropped.
    - HOLD -> REQ with inst_valid<=0. If inst_ready is 1 the same cycle, the handshake counts as completed (decoder took the word), but the redirect target replaces pc+4.
    - DRAIN -> stays DRAIN (-> REQ if rsp_valid the same cycle).
    - ERR -> REQ.
  - Misaligned target: fetch_err<=1, pc<=redirect_pc.
    - Outstanding request (WAIT without rsp, or REQ accepted that cycle) -> DRAIN, then ERR instead of REQ.
    - Otherwise -> ERR.
- Decoder never sees an instruction fetched before a redirect once the redirect cycle has passed.
- Steady-state throughput with zero-wait memory and inst_ready=1: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Reset mid-operation: any outstanding response arriving after reset is not tracked; the memory side is reset with the same rst_n.

Test Plan:
- Reset release, req_ready=1 always, response 1 cycle after accept, inst_ready=1 -> addresses 8000_0000, 8000_0004, 8000_0008; each inst_valid carries the matching inst_pc and memory data.
- Hold inst_ready=0 for 5 cycles in HOLD -> inst, inst_pc, inst_valid stable; no new imem_req_valid; pc advances only after ready.
- Redirect to 8000_0100 while in WAIT, response returns 2 cycles later with 0xDEADBEEF -> 0xDEADBEEF never presented; next request addr 8000_0100.
- Redirect to 8000_0040 in the same cycle as inst_ready in HOLD -> next request addr 8000_0040, not pc+4.
- Redirect to 8000_0102 -> fetch_err=1, no requests, inst_valid=0; then redirect 8000_0200 -> fetch_err=0, request at 8000_0200.
- pc=FFFF_FFFC consumed -> next request addr 0000_0000; assert rst_n=0 while in WAIT -> outputs return to reset values, first request at RESET_PC.
